// File: rtl/gpio_irq_pkg.sv
// Shared register offsets and field positions for the GPIO interrupt aggregator.
// Pure definitions: no latency or backpressure of its own.
package gpio_irq_pkg;
  localparam logic [7:0] ADDR_PENDING    = 8'h00;
  localparam logic [7:0] ADDR_ENABLE     = 8'h04;
  localparam logic [7:0] ADDR_RAW        = 8'h08;
  localparam logic [7:0] ADDR_ACTIVE     = 8'h0C;
  localparam logic [7:0] ADDR_CLAIM      = 8'h10;
  localparam int         CLAIM_VALID_BIT = 31;
endpackage

// File: rtl/gpio_irq_prio_enc.sv
// Lowest-index-first priority encoder over the active interrupt vector.
// Purely combinational; no backpressure.
module gpio_irq_prio_enc #(
  parameter int NUM_IN = 16,
  parameter int ID_W   = 5
) (
  input  logic [NUM_IN-1:0] vec_i,
  output logic [ID_W-1:0]   id_o,
  output logic              any_o
);

  always_comb begin
    id_o  = '0;
    any_o = |vec_i;
    // Walk downwards so the lowest set index is the last one written.
    for (int i = NUM_IN - 1; i >= 0; i--) begin
      if (vec_i[i]) id_o = ID_W'(i);
    end
  end

endmodule

// File: rtl/gpio_irq_aggregator.sv
// Rising-edge capture of GPIO interrupt lines into PENDING, masked by ENABLE, ORed into a registered IRQ.
// PENDING sets one edge after INT_IN rises, IRQ one edge later; zero-wait APB3 slave, PREADY tied high.
module gpio_irq_aggregator
  import gpio_irq_pkg::*;
#(
  parameter int NUM_IN = 16,
  parameter int ID_W   = 5
) (
  input  logic              PCLK,
  input  logic              PRESET,
  input  logic [NUM_IN-1:0] INT_IN,
  input  logic [7:0]        PADDR,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [31:0]       PWDATA,
  output logic [31:0]       PRDATA,
  output logic              PREADY,
  output logic              PSLVERR,
  output logic              IRQ
);

  logic [NUM_IN-1:0] int_q, pending_q, pending_d, enable_q, enable_d;
  logic              irq_q;
  logic [NUM_IN-1:0] rise, active, clr_w1c, clr_claim;
  logic [ID_W-1:0]   claim_id;
  logic              claim_any;
  logic              access, wr, rd;
  logic [7:0]        addr;
  logic              unused_bits;

  assign addr        = {PADDR[7:2], 2'b00};
  assign access      = PSEL & PENABLE;
  assign wr          = access & PWRITE;
  assign rd          = access & ~PWRITE;
  assign rise        = INT_IN & ~int_q;
  assign active      = pending_q & enable_q;
  assign unused_bits = ^{PADDR[1:0], PWDATA[31:NUM_IN]};

  gpio_irq_prio_enc #(
    .NUM_IN(NUM_IN),
    .ID_W  (ID_W)
  ) u_prio_enc (
    .vec_i(active),
    .id_o (claim_id),
    .any_o(claim_any)
  );

  always_comb begin
    clr_w1c   = '0;
    clr_claim = '0;
    if (wr && addr == ADDR_PENDING) clr_w1c = PWDATA[NUM_IN-1:0];
    if (rd && addr == ADDR_CLAIM && claim_any) clr_claim = NUM_IN'(1) << claim_id;
    // A new edge on the same cycle as a clear keeps the bit set.
    pending_d = (pending_q & ~(clr_w1c | clr_claim)) | rise;
    enable_d  = (wr && addr == ADDR_ENABLE) ? PWDATA[NUM_IN-1:0] : enable_q;
  end

  always_comb begin
    PRDATA  = '0;
    PSLVERR = 1'b0;
    if (access) begin
      case (addr)
        ADDR_PENDING: PRDATA[NUM_IN-1:0] = pending_q;
        ADDR_ENABLE:  PRDATA[NUM_IN-1:0] = enable_q;
        ADDR_RAW:     PRDATA[NUM_IN-1:0] = INT_IN;
        ADDR_ACTIVE:  PRDATA[NUM_IN-1:0] = active;
        ADDR_CLAIM: begin
          PRDATA[CLAIM_VALID_BIT] = claim_any;
          PRDATA[ID_W-1:0]        = claim_any ? claim_id : '0;
        end
        default:      PSLVERR = 1'b1;
      endcase
    end
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      int_q     <= '0;
      pending_q <= '0;
      enable_q  <= '0;
      irq_q     <= 1'b0;
    end else begin
      int_q     <= INT_IN;
      pending_q <= pending_d;
      enable_q  <= enable_d;
      irq_q     <= |active;
    end
  end

  assign PREADY = 1'b1;
  assign IRQ    = irq_q;

endmodule
